contadores_n: RTL and testbench

//  Parametrised per-FIFO pop counter for the transaction layer; successor of the 4-channel, 5-bit counter block.

---
 rtl/contadores_n_if.sv | 14 +
 rtl/contadores_n.sv | 100 ++++++++++
 tb/tb_contadores_n.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/contadores_n_if.sv
// Readout channel of the pop-counter block: request and channel index from the
// config side, count and its one-cycle qualifier back to it.
interface contadores_n_if #(
  parameter int IDXW = 2,
  parameter int CW   = 5
);
  logic            req;
  logic [IDXW-1:0] idx;
  logic [CW-1:0]   data;
  logic            valid;

  modport master (output req, idx, input  data, valid);
  modport slave  (input  req, idx, output data, valid);
endinterface

// File: rtl/contadores_n.sv
// Per-FIFO pop counters with wrap/saturate, sticky overflow flags, optional
// clear-on-read and an idle-gated request/response readout FSM.
module contadores_n #(
  parameter int NCH       = 4,
  parameter int CW        = 5,
  parameter int IDXW      = 2,
  parameter int SAT_MODE  = 0,
  parameter int CLR_ON_RD = 0
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic [NCH-1:0]   pop,
  input  logic [NCH-1:0]   empty,
  input  logic             idle,
  contadores_n_if.slave    rd,
  output logic [NCH-1:0]   ovf
);

  typedef enum logic [1:0] {CNT, RDY, RESP} state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t         state;
  logic [CW-1:0]  cnt [NCH];
  logic [NCH-1:0] cnt_ev;
  logic [NCH-1:0] at_max;
  logic [NCH-1:0] clr_hit;
  logic [CW-1:0]  rd_val;
  logic           rd_fire;

  assign rd_fire = (state == RDY) && idle && rd.req;

  // An index with no matching channel leaves rd_val at 0, which is exactly the
  // response required for idx >= NCH.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    rd_val  = '0;
    cnt_ev  = '0;
    at_max  = '0;
    clr_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_ev[i]  = pop[i] & ~empty[i];
      at_max[i]  = (cnt[i] == CNT_MAX);
      clr_hit[i] = (CLR_ON_RD != 0) && rd_fire && (rd.idx == IDXW'(i));
      if (rd.idx == IDXW'(i)) rd_val = cnt[i];
    end
  end

  // Counters run in every FSM state; a clear-on-read replaces the old value but
  // still honours a same-edge count event.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      // NOTE: the counters are plain flops, not a RAM, so they take the async reset.
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
      ovf <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr_hit[i]) begin
          cnt[i] <= cnt_ev[i] ? CW'(1) : '0;
          ovf[i] <= cnt_ev[i] & at_max[i];
        end else if (cnt_ev[i]) begin
          if (at_max[i]) begin
            ovf[i] <= 1'b1;
            cnt[i] <= (SAT_MODE != 0) ? CNT_MAX : '0;
          end else begin
            // NOTE: non-blocking, so rd_val below still sees the pre-edge count.
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  // Readout FSM: requests are accepted only from RDY; valid is a registered
  // one-cycle pulse that coincides with the RESP state.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state    <= CNT;
      rd.data  <= '0;
      rd.valid <= 1'b0;
    end else begin
      rd.valid <= 1'b0;
      case (state)
        CNT: if (idle) state <= RDY;
        RDY: begin
          if (!idle) begin
            state <= CNT;
          end else if (rd.req) begin
            state    <= RESP;
            rd.valid <= 1'b1;
            rd.data  <= rd_val;
          end
        end
        RESP:    state <= idle ? RDY : CNT;
        default: state <= CNT;
      endcase
    end
  end

endmodule

// File: tb/tb_contadores_n.sv
// Scoreboard bench for contadores_n: five parameter variants share one stimulus
// stream, each with its own arithmetic reference model and response queue.
module tb_contadores_n;

  localparam int N_CFG = 5;
  localparam int CW    = 5;
  localparam int MAXV  = (1 << CW) - 1;

  typedef enum {P_DATA, P_OVF, P_VALID} probe_t;

  function automatic int nch_of(input int g); return (g == 4) ? 3 : 4; endfunction
  function automatic int sat_of(input int g); return (g == 1 || g == 3) ? 1 : 0; endfunction
  function automatic int clr_of(input int g); return (g >= 2) ? 1 : 0; endfunction

  logic       clk = 1'b0;
  logic       rst_l = 1'b1;
  logic [3:0] pop, empty;
  logic       idle, req;
  logic [1:0] idx;

  int checks = 0;
  int errors = 0;

  event   probe_ev;
  probe_t probe_kind;
  string  probe_name;
  int     probe_exp [N_CFG];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < N_CFG; g++) begin : cfg
    localparam int NCH = nch_of(g);
    localparam int SAT = sat_of(g);
    localparam int CLR = clr_of(g);

    contadores_n_if #(.IDXW(2), .CW(CW)) bus ();
    logic [NCH-1:0] ovf;

    assign bus.req = req;
    assign bus.idx = idx;

    contadores_n #(
      .NCH(NCH), .CW(CW), .IDXW(2), .SAT_MODE(SAT), .CLR_ON_RD(CLR)
    ) dut (
      .clk   (clk),
      .rst_l (rst_l),
      .pop   (pop[NCH-1:0]),
      .empty (empty[NCH-1:0]),
      .idle  (idle),
      .rd    (bus),
      .ovf   (ovf)
    );

    // Reference model: counts as integers, flags as a bitmask, readout gated by
    // "idle seen on the previous edge and no response in flight".
    int             m_cnt [NCH];
    logic [NCH-1:0] m_ovf;
    bit             m_open, m_busy, accept, ev;
    int             rd_cnt;
    logic [CW-1:0]  exp_q [$];
    logic [CW-1:0]  exp_d;

    always @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
        m_ovf  = '0;
        m_open = 1'b0;
        m_busy = 1'b0;
        exp_q.delete();
      end else begin
        accept = 1'b0;
        if (m_busy) begin
          m_busy = 1'b0;
          m_open = idle;
        end else if (!m_open) begin
          m_open = idle;
        end else if (!idle) begin
          m_open = 1'b0;
        end else if (req) begin
          accept = 1'b1;
          m_busy = 1'b1;
        end
        if (accept) begin
          rd_cnt = 0;
          for (int i = 0; i < NCH; i++) if (int'(idx) == i) rd_cnt = m_cnt[i];
          exp_q.push_back(CW'(rd_cnt));
        end
        for (int i = 0; i < NCH; i++) begin
          ev = pop[i] && !empty[i];
          if (accept && CLR != 0 && int'(idx) == i) begin
            m_ovf[i] = ev && (m_cnt[i] == MAXV);
            m_cnt[i] = ev ? 1 : 0;
          end else if (ev) begin
            if (m_cnt[i] + 1 > MAXV) begin
              m_ovf[i] = 1'b1;
              m_cnt[i] = (SAT != 0) ? MAXV : 0;
            end else begin
              m_cnt[i] = m_cnt[i] + 1;
            end
          end
        end
      end
    end

    always @(negedge clk) begin
      if (rst_l) begin
        check($sformatf("cfg%0d valid", g), 32'(bus.valid), (exp_q.size() != 0) ? 1 : 0);
        if (exp_q.size() != 0) begin
          exp_d = exp_q.pop_front();
          if (bus.valid) check($sformatf("cfg%0d data", g), 32'(bus.data), 32'(exp_d));
        end
        check($sformatf("cfg%0d ovf", g), 32'(ovf), 32'(m_ovf));
      end
    end

    always @(probe_ev) begin
      case (probe_kind)
        P_DATA:  check($sformatf("cfg%0d %s", g, probe_name), 32'(bus.data), probe_exp[g]);
        P_OVF:   check($sformatf("cfg%0d %s", g, probe_name), 32'(ovf), probe_exp[g]);
        default: check($sformatf("cfg%0d %s", g, probe_name), 32'(bus.valid), probe_exp[g]);
      endcase
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic probe5(input probe_t k, input string nm,
                        input int e0, input int e1, input int e2, input int e3, input int e4);
    probe_kind = k;
    probe_name = nm;
    probe_exp  = '{e0, e1, e2, e3, e4};
    -> probe_ev;
    #1;
  endtask

  task automatic probe_same(input probe_t k, input string nm, input int e);
    probe5(k, nm, e, e, e, e, e);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst_l = 1'b0;
    pop = '0;
    req = 1'b0;
    @(negedge clk);
    #2 rst_l = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [1:0] ch);
    idx = ch;
    req = 1'b1;
    cyc(1);
    req = 1'b0;
    cyc(1);
  endtask

  initial begin
    pop = '0; empty = '0; idle = 1'b0; req = 1'b0; idx = '0;
    rst_l = 1'b0;
    #2;
    probe_same(P_VALID, "reset valid", 0);
    probe_same(P_DATA,  "reset data", 0);
    probe_same(P_OVF,   "reset ovf", 0);
    @(negedge clk);
    rst_l = 1'b1;

    // Simultaneous pops on all channels, then read channel 2.
    idle = 1'b1;
    pop  = 4'hF;
    cyc(4);
    pop = '0;
    do_read(2);
    probe_same(P_DATA, "four pops", 4);
    probe_same(P_OVF,  "no ovf", 0);

    // Pops against an empty FIFO are not counted.
    apply_reset();
    pop = 4'b0010; empty = 4'b0010;
    cyc(3);
    pop = '0; empty = '0;
    do_read(1);
    probe_same(P_DATA, "pop on empty", 0);

    // 33 pops on ch0: wrap gives 1, saturate gives 31; overflow flagged either way.
    apply_reset();
    pop = 4'b0001;
    cyc(33);
    pop = '0;
    probe_same(P_OVF, "ch0 ovf", 1);
    do_read(0);
    probe5(P_DATA, "33 pops", 1, 31, 1, 31, 1);

    // A request while not idle is dropped; counting continues regardless.
    idle = 1'b0; idx = 2'd3; req = 1'b1;
    cyc(1);
    req = 1'b0;
    pop = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      probe_same(P_VALID, "busy no valid", 0);
    end
    pop  = '0;
    idle = 1'b1;
    cyc(1);
    do_read(3);
    probe5(P_DATA, "idx3 after idle", 4, 4, 4, 4, 0);

    // Read of ch2 with a same-edge pop, then read again.
    apply_reset();
    pop = 4'b0100;
    cyc(7);
    idx = 2'd2; req = 1'b1;
    cyc(1);
    req = 1'b0; pop = '0;
    cyc(1);
    probe_same(P_DATA, "read with pop", 7);
    do_read(2);
    probe5(P_DATA, "second read", 8, 8, 1, 1, 1);

    // Reset asserted during the response cycle.
    apply_reset();
    pop = 4'b0010;
    cyc(3);
    pop = '0; idx = 2'd1; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    probe_same(P_VALID, "resp valid", 1);
    probe_same(P_DATA,  "resp data", 3);
    rst_l = 1'b0;
    #1;
    probe_same(P_VALID, "async rst valid", 0);
    probe_same(P_DATA,  "async rst data", 0);
    probe_same(P_OVF,   "async rst ovf", 0);
    @(negedge clk);
    #2 rst_l = 1'b1;
    cyc(2);
    do_read(1);
    probe_same(P_DATA, "count after rst", 0);

    // Randomised traffic against the models.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) idle = ~idle;
      req   = ($urandom_range(0, 3) == 0);
      idx   = 2'($urandom);
      pop   = 4'($urandom);
      empty = 4'($urandom) & 4'($urandom);
    end
    req = 1'b0; pop = '0; empty = '0;
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
